mmio_dbus_bridge: RTL
=====================

# mmio_dbus_bridge

Data-bus decoder that sits directly downstream of the RV32 core's data port (`data_ce`, `data_we`, `data_addr`, `data_o`, `data_i`). It routes accesses to the external data RAM or to a small MMIO register file. The MMIO register file contains:
- a buffered UART transmitter (FIFO plus serializer FSM),
- a free-running cycle counter,
- a programmable baud divisor.

Reads are combinational so that the core's MEM stage receives read data in the same cycle. Writes commit on the rising clock edge.

## Interface
Parameters:
- `RAM_BASE`, `32'h0000_0000`: RAM window base address; must be aligned to the window size.
- `RAM_AW`, `12`: log2 of the RAM window size in bytes.
- `MMIO_BASE`, `32'h1000_0000`: base address of the 16-byte MMIO window.
- `FIFO_DEPTH`, `8`: TX FIFO depth; must be a power of two, ≥2.
- `CLK_DIV`, `16`: reset value of the baud divisor (clocks per bit).

Ports:
- `clk` in 1: system clock; all state is updated on the rising edge.
- `clrn` in 1: asynchronous, active-low reset.
- `data_ce_i` in 1: core data access enable.
- `data_we_i` in 1: core write strobe; qualified by `data_ce_i`.
- `data_addr_i` in 32: byte address.
- `data_wdata_i` in 32: store data.
- `data_rdata_o` out 32: load data (combinational).
- `ram_ce_o` in/out: `ram_ce_o` out 1, equal to `data_ce_i` AND RAM hit.
- `ram_we_o` out 1: equal to `data_we_i` AND `ram_ce_o`.
- `ram_addr_o` out 32: `data_addr_i`, passed through unchanged.
- `ram_wdata_o` out 32: `data_wdata_i`, passed through unchanged.
- `ram_rdata_i` in 32: RAM read data (combinational).
- `uart_tx_o` out 1: serial output, registered; idles high.

## Operation
Address decode:
- RAM hit: `addr[31:RAM_AW] == RAM_BASE[31:RAM_AW]`.
- MMIO hit: `addr[31:4] == MMIO_BASE[31:4]`. The register is selected by `addr[3:2]`; `addr[1:0]` is ignored.
- No hit: reads return 0 and writes are ignored.
- When `data_ce_i` = 0, `data_rdata_o` = 0.

MMIO registers (offset):
- `0x0` TXDATA.
  - A write pushes `wdata[7:0]` into the FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and the sticky `OVF` bit is set.
  - Reads return 0.
- `0x4` STATUS.
  - Read value: `{28'b0, OVF, BUSY, FULL, EMPTY}`.
  - A write with `wdata[3]` = 1 clears `OVF`. If an overflow occurs in the same cycle, the set takes priority.
- `0x8` CYCLE: 32-bit counter that increments every cycle and wraps from `FFFF_FFFF` to 0.
  - A write loads `wdata`; the write wins over the increment in that cycle.
  - Reads return the current registered value.
- `0xC` BAUDDIV: 16-bit divisor, read zero-extended.
  - Writes take effect at the next START; the bit in flight is not affected.
  - A value of 0 is treated as 1.

TX FIFO:
- Circular buffer with read and write pointers that are log2(`FIFO_DEPTH`)+1 bits wide; the extra bit distinguishes full from empty.
- `EMPTY` and `FULL` are derived from the pointers.
- A simultaneous push and pop leaves the count unchanged.

Serializer FSM: IDLE → START → DATA → STOP → (START or IDLE).
- IDLE: `uart_tx_o` = 1. If the FIFO is non-empty: pop into the shift register, latch BAUDDIV, go to START.
- START: `uart_tx_o` = 0 for DIV cycles.
- DATA: 8 bits, LSB first, each held for DIV cycles. A 3-bit bit index selects the bit.
- STOP: `uart_tx_o` = 1 for DIV cycles. At the end:
  - FIFO non-empty: pop and go directly to START, with no idle cycle.
  - FIFO empty: go to IDLE.
- `BUSY` = (state ≠ IDLE).
- Bit timing uses a 16-bit down-counter reloaded with the latched DIV.

Reset (`clrn` low, at any time, including mid-frame):
- State → IDLE; FIFO pointers → 0; `OVF` → 0; CYCLE → 0; BAUDDIV → `CLK_DIV`.
- `uart_tx_o` → 1.
- Any frame in progress is abandoned and FIFO contents are lost.
- Combinational outputs follow the inputs.

## Timing
- Read latency is 0 cycles. Write latency is 1 edge.
- A TXDATA write at edge E makes the FIFO non-empty after E.
- The pop happens at edge E+1, and `uart_tx_o` falls after E+1.
- One frame lasts 10·DIV cycles.
- A STATUS read in the cycle after a push shows `EMPTY` = 0, or the FIFO already popped and `BUSY` = 1.
- `uart_tx_o` is glitch-free because it is driven directly from a flop.

## Test plan
- Reset check: drive `clrn` low mid-frame and release it. Required: `uart_tx_o` = 1, STATUS = `0x1`, CYCLE = 0 then increments, BAUDDIV = 16.
- Single byte: with BAUDDIV = 4, write `0xA5` to TXDATA. Required: starting 1 cycle after the write, `uart_tx_o` = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high for 4 cycles; STATUS = `0x1` afterwards.
- Overflow: with BAUDDIV = 100, write `FIFO_DEPTH`+2 bytes back-to-back. Required: the first byte is popped and exactly one byte is dropped; `OVF` = 1 and `FULL` = 1; writing `0x8` to STATUS clears `OVF`; the 9 accepted bytes are transmitted in order with no idle gap.
- Cycle counter: write `FFFF_FFFE` to CYCLE. Required: reads return `FFFF_FFFE`, then `FFFF_FFFF`, then `0000_0000` on consecutive cycles.
- Decode: a RAM write at `0x0000_0FFC` asserts `ram_ce_o` and `ram_we_o`; a read there returns `ram_rdata_i`. A read at `0x2000_0000` returns 0 and asserts no strobes. A write at `0x1000_0010` changes no state.
- Baud change mid-frame: write BAUDDIV = 8 during the DATA phase of a DIV = 4 frame. Required: the current frame finishes at 4 cycles/bit; the next frame runs at 8 cycles/bit.

Source files
------------

// File: rtl/mmio_dbus_bridge.sv
// Data-bus decoder between the RV32 core data port, external RAM and a small
// MMIO block (buffered UART transmitter, cycle counter, baud divisor).
module mmio_dbus_bridge #(
  parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
  parameter int          RAM_AW     = 12,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          CLK_DIV    = 16
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        data_ce_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i,
  output logic        uart_tx_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // ---------------------------------------------------------------- decode
  logic ram_hit, mmio_hit, mmio_wr;
  logic wr_txdata, wr_status, wr_cycle, wr_baud;

  assign ram_hit  = (data_addr_i[31:RAM_AW] == RAM_BASE[31:RAM_AW]);
  assign mmio_hit = (data_addr_i[31:4] == MMIO_BASE[31:4]) && !ram_hit;
  assign mmio_wr  = data_ce_i && data_we_i && mmio_hit;

  assign wr_txdata = mmio_wr && (data_addr_i[3:2] == 2'd0);
  assign wr_status = mmio_wr && (data_addr_i[3:2] == 2'd1);
  assign wr_cycle  = mmio_wr && (data_addr_i[3:2] == 2'd2);
  assign wr_baud   = mmio_wr && (data_addr_i[3:2] == 2'd3);

  assign ram_ce_o    = data_ce_i && ram_hit;
  assign ram_we_o    = data_we_i && ram_ce_o;
  assign ram_addr_o  = data_addr_i;
  assign ram_wdata_o = data_wdata_i;

  // ---------------------------------------------------------------- state
  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   div_lat_q, div_lat_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   cycle_q, cycle_d;
  logic [15:0]   baud_q, baud_d;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic          fifo_empty, fifo_full, push, pop, busy;
  logic [15:0]   div_eff;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
  assign push    = wr_txdata && (!fifo_full || pop);
  assign busy    = (state_q != S_IDLE);
  assign div_eff = (baud_q == 16'd0) ? 16'd1 : baud_q;

  // NOTE: storage arrays carry no reset; pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= data_wdata_i[7:0];
  end

  // ---------------------------------------------------------------- registers
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    ovf_d = ovf_q;
    if (wr_status && data_wdata_i[3]) ovf_d = 1'b0;
    if (wr_txdata && fifo_full && !pop) ovf_d = 1'b1;

    cycle_d = wr_cycle ? data_wdata_i : cycle_q + 32'd1;
    baud_d  = wr_baud ? data_wdata_i[15:0] : baud_q;
  end

  // ---------------------------------------------------------------- serializer next state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    div_lat_d = div_lat_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == 16'd0) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
          cnt_d     = div_lat_q - 16'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = div_lat_q - 16'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == 16'd0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // The divisor is sampled only when a frame begins.
    if (pop) begin
      shift_d   = fifo_mem[rd_ptr_q[PTR_W-1:0]];
      div_lat_d = div_eff;
      cnt_d     = div_eff - 16'd1;
    end
  end

  // ---------------------------------------------------------------- serializer output
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_lat_q <= 16'd1;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
      cycle_q   <= '0;
      baud_q    <= 16'(CLK_DIV);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_lat_q <= div_lat_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_q     <= ovf_d;
      cycle_q   <= cycle_d;
      baud_q    <= baud_d;
    end
  end

  assign uart_tx_o = tx_q;

  // ---------------------------------------------------------------- read mux
  always_comb begin
    data_rdata_o = '0;
    if (data_ce_i) begin
      if (ram_hit) begin
        data_rdata_o = ram_rdata_i;
      end else if (mmio_hit) begin
        case (data_addr_i[3:2])
          2'd1:    data_rdata_o = {28'b0, ovf_q, busy, fifo_full, fifo_empty};
          2'd2:    data_rdata_o = cycle_q;
          2'd3:    data_rdata_o = {16'b0, baud_q};
          default: data_rdata_o = '0;
        endcase
      end
    end
  end

endmodule
